// File: rtl/fabric_spi_pkg.sv
// fabric_spi_pkg: shared state type and constants for the fabric SPI bitstream path
package fabric_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} spi_tx_state_e;
  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;
  localparam int BITSTREAM_WORD_W = 32;
endpackage

// File: rtl/fabric_spi_clkgen.sv
// fabric_spi_clkgen: sclk half-period timer; in clk_i rst_i start_i(clear) en_i, out rise_tick fall_tick
module fabric_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q;
  logic hi_q;
  logic wrap;
  assign wrap = en_i && cnt_q == CW'(CLK_DIV - 1);
  assign rise_tick = wrap && !hi_q;
  assign fall_tick = wrap && hi_q;
  always_ff @(posedge clk_i)
    if (rst_i || start_i) begin
      cnt_q <= '0;
      hi_q <= 1'b0;
    end else if (en_i) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      hi_q <= hi_q ^ wrap;
    end
endmodule

// File: rtl/fabric_spi_bitstream_tx.sv
// fabric_spi_bitstream_tx: mode-0 SPI initiator; clk_i rst_i, word_i valid_i last_i ready_o in, sclk_o cs_no mosi_o miso_i SPI, busy_o words_sent_o rx_word_o rx_valid_o status
module fabric_spi_bitstream_tx
  import fabric_spi_pkg::*;
#(
  parameter int WORD_W   = BITSTREAM_WORD_W,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [15:0]       words_sent_o,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
  output logic              sclk_o,
  output logic              cs_no,
  output logic              mosi_o,
  input  logic              miso_i
);
  localparam int BW = $clog2(WORD_W);
  localparam int DM0 = CS_SETUP > CLK_DIV ? CS_SETUP : CLK_DIV;
  localparam int DMAX = DM0 > CS_GAP ? DM0 : CS_GAP;
  localparam int DW = $clog2(DMAX + 1);
  spi_tx_state_e state_q, state_d;
  logic [WORD_W-1:0] sh_q, rx_sh_q;
  logic [BW-1:0] bit_q;
  logic [DW-1:0] dly_q, dly_lim;
  logic last_q, rise, fall, accept, word_done, dly_done;
  fabric_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (state_q != SHIFT),
    .en_i     (state_q == SHIFT),
    .rise_tick(rise),
    .fall_tick(fall)
  );
  assign ready_o = state_q == IDLE || state_q == WAIT;
  assign busy_o = state_q != IDLE;
  assign accept = valid_i && ready_o;
  assign word_done = fall && bit_q == BW'(WORD_W - 1);
  assign mosi_o = sh_q[WORD_W-1];
  assign dly_done = dly_q == dly_lim;
  always_comb
    dly_lim = state_q == SETUP ? DW'(CS_SETUP - 1) :
              state_q == HOLD  ? DW'(CLK_DIV - 1)  : DW'(CS_GAP - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (dly_done) state_d = SHIFT;
      SHIFT:   if (word_done) state_d = last_q ? HOLD : WAIT;
      WAIT:    if (accept) state_d = SHIFT;
      HOLD:    if (dly_done) state_d = GAP;
      GAP:     if (dly_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      dly_q <= '0;
      cs_no <= 1'b1;
      sclk_o <= 1'b0;
      sh_q <= '0;
      rx_sh_q <= '0;
      bit_q <= '0;
      last_q <= 1'b0;
      rx_word_o <= '0;
      rx_valid_o <= 1'b0;
      words_sent_o <= '0;
    end else begin
      state_q <= state_d;
      dly_q <= state_d != state_q ? '0 : dly_q + 1'b1;
      cs_no <= state_d == IDLE || state_d == GAP;
      rx_valid_o <= word_done;
      if (accept) begin
        sh_q <= word_i;
        last_q <= last_i;
        bit_q <= '0;
      end
      if (rise) begin
        sclk_o <= 1'b1;
        rx_sh_q <= {rx_sh_q[WORD_W-2:0], miso_i};
      end
      if (fall) begin
        sclk_o <= 1'b0;
        sh_q <= sh_q << 1;
        bit_q <= bit_q + 1'b1;
      end
      if (word_done) begin
        rx_word_o <= rx_sh_q;
        words_sent_o <= words_sent_o == 16'hFFFF ? words_sent_o : words_sent_o + 16'd1;
      end
    end
endmodule

// File: tb/tb_fabric_spi_bitstream_tx.sv
// tb_fabric_spi_bitstream_tx: self-checking bench for fabric_spi_bitstream_tx
module tb_fabric_spi_bitstream_tx;
  localparam int W = 32;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP = 4;
  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] mw;
    logic         loop;
    logic [W-1:0] exp_rx;
    int           exp_low;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] word = '0;
  logic last = 1'b0, v0 = 1'b0, v1 = 1'b0, loop = 1'b0;
  logic rdy0, busy0, rxv0, sclk0, cs0, mosi0, miso0;
  logic rdy1, busy1, rxv1, sclk1, cs1, mosi1;
  logic [15:0] ws0, ws1;
  logic [W-1:0] rxw0, rxw1;
  int total = 0, bad = 0, exp_ws = 0;
  logic [W-1:0] tx [4];
  logic [W-1:0] mw [4];
  logic [W-1:0] erx [4];
  logic mon_q[$];
  logic [W-1:0] rx_q[$];
  int rises = 0, fbits = 0, lowcnt = 0, last_low = 0, hicnt = 0, low1 = 0, last_low1 = 0;
  logic ps0 = 1'b0, pc0 = 1'b1, pc1 = 1'b1;
  logic [W-1:0] cur_mw;
  always #5 clk = ~clk;
  fabric_spi_bitstream_tx #(.WORD_W(W), .CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk_i(clk), .rst_i(rst), .word_i(word), .valid_i(v0), .last_i(last), .ready_o(rdy0),
    .busy_o(busy0), .words_sent_o(ws0), .rx_word_o(rxw0), .rx_valid_o(rxv0), .sclk_o(sclk0),
    .cs_no(cs0), .mosi_o(mosi0), .miso_i(miso0)
  );
  fabric_spi_bitstream_tx #(.WORD_W(W), .CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut1 (
    .clk_i(clk), .rst_i(rst), .word_i(word), .valid_i(v1), .last_i(last), .ready_o(rdy1),
    .busy_o(busy1), .words_sent_o(ws1), .rx_word_o(rxw1), .rx_valid_o(rxv1), .sclk_o(sclk1),
    .cs_no(cs1), .mosi_o(mosi1), .miso_i(mosi1)
  );
  always_comb cur_mw = mw[(fbits / W) % 4];
  assign miso0 = loop ? mosi0 : cur_mw[W-1-(fbits % W)];
  always @(negedge clk) begin
    if (!cs0 && pc0) begin
      mon_q.delete();
      rx_q.delete();
      rises <= 0;
      fbits <= 0;
    end else if (sclk0 && !ps0) begin
      mon_q.push_back(mosi0);
      rises <= rises + 1;
      fbits <= fbits + 1;
    end
    if (rxv0) rx_q.push_back(rxw0);
    if (!cs0) lowcnt <= pc0 ? 1 : lowcnt + 1;
    if (cs0 && !pc0) last_low <= lowcnt;
    if (cs0) hicnt <= pc0 ? hicnt + 1 : 1;
    if (!cs1) low1 <= pc1 ? 1 : low1 + 1;
    if (cs1 && !pc1) last_low1 <= low1;
    ps0 <= sclk0;
    pc0 <= cs0;
    pc1 <= cs1;
  end
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic run_frame(input int n, input int stall, input int exp_low);
    int t;
    logic ok;
    logic [W-1:0] got;
    for (int i = 0; i < n; i++) begin
      word = tx[i];
      last = (i == n - 1);
      v0 = 1'b1;
      t = 0;
      while (!rdy0 && t < 1000) begin tick; t++; end
      check("accept_bound", t < 1000, 1);
      tick;
      if (i < n - 1 && stall > 0) begin
        v0 = 1'b0;
        t = 0;
        while (!rdy0 && t < 1000) begin tick; t++; end
        ok = 1'b1;
        repeat (stall) begin
          tick;
          ok &= !cs0 && !sclk0 && rdy0;
        end
        check("wait_stall", ok, 1);
      end
    end
    v0 = 1'b0;
    last = 1'b0;
    t = 0;
    while (busy0 && t < 2000) begin tick; t++; end
    check("busy_end", busy0, 0);
    check("sclk_rises", rises, 32 * n);
    for (int i = 0; i < n; i++) begin
      got = '0;
      for (int j = 0; j < W; j++)
        if (i * W + j < mon_q.size()) got = {got[W-2:0], mon_q[i*W+j]};
      check("mosi_word", got, tx[i]);
    end
    check("rx_pulses", rx_q.size(), n);
    for (int i = 0; i < n; i++)
      check("rx_word", i < rx_q.size() ? rx_q[i] : '0, erx[i]);
    check("cs_low_len", last_low, exp_low);
    check("cs_gap_len", hicnt, CS_GAP + 1);
    exp_ws = exp_ws + n > 65535 ? 65535 : exp_ws + n;
    check("words_sent", ws0, exp_ws);
  endtask
  initial begin
    vec_t tbl [5];
    int t, n, s;
    tbl[0] = '{32'hA5C3_0F01, 32'h1234_5678, 1'b0, 32'h1234_5678, 132};
    tbl[1] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 132};
    tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 132};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 132};
    tbl[4] = '{32'h8000_0001, 32'h5A5A_A5A5, 1'b1, 32'h8000_0001, 132};
    repeat (3) tick;
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_cs", cs0, 1);
    check("rst_sclk", sclk0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_ws", ws0, 0);
    check("rst_rxw", rxw0, 0);
    check("rst_rxv", rxv0, 0);
    rst = 1'b0;
    repeat (2) tick;
    for (int k = 0; k < 5; k++) begin
      tx[0] = tbl[k].word;
      mw[0] = tbl[k].mw;
      loop = tbl[k].loop;
      erx[0] = tbl[k].exp_rx;
      run_frame(1, 0, tbl[k].exp_low);
    end
    loop = 1'b0;
    tx[0] = 32'h1; tx[1] = 32'h2; tx[2] = 32'hFFFF_FFFF;
    mw[0] = 32'hC001_D00D; mw[1] = 32'h0BAD_F00D; mw[2] = 32'h7777_1111;
    for (int i = 0; i < 3; i++) erx[i] = mw[i];
    run_frame(3, 0, CS_SETUP + 3 * 128 + 2 + 2);
    tx[0] = 32'h1357_9BDF; tx[1] = 32'h2468_ACE0;
    for (int i = 0; i < 2; i++) erx[i] = mw[i];
    run_frame(2, 50, CS_SETUP + 2 * 128 + 51 + 2);
    tx[0] = 32'h0F0F_3C3C;
    word = tx[0];
    last = 1'b1;
    v0 = 1'b1;
    tick;
    v0 = 1'b0;
    t = 0;
    while (rises < 10 && t < 2000) begin tick; t++; end
    check("rst_mid_reach", rises, 10);
    rst = 1'b1;
    tick;
    check("mid_rst_cs", cs0, 1);
    check("mid_rst_sclk", sclk0, 0);
    check("mid_rst_ws", ws0, 0);
    check("mid_rst_ready", rdy0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rxw", rxw0, 0);
    rst = 1'b0;
    exp_ws = 0;
    tick;
    tx[0] = 32'hCAFE_F00D;
    erx[0] = mw[0];
    run_frame(1, 0, 132);
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      s = $urandom_range(0, 3);
      loop = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        tx[i] = $urandom;
        mw[i] = $urandom;
        erx[i] = loop ? tx[i] : mw[i];
      end
      run_frame(n, s, CS_SETUP + n * 128 + (n - 1) * (s + 1) + 2);
    end
    loop = 1'b0;
    force dut1.words_sent_o = 16'hFFFE;
    tick;
    release dut1.words_sent_o;
    tick;
    check("sat_preload", ws1, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      word = 32'h600D_0000 + i;
      last = (i == 2);
      v1 = 1'b1;
      t = 0;
      while (!rdy1 && t < 1000) begin tick; t++; end
      check("div1_accept", t < 1000, 1);
      tick;
    end
    v1 = 1'b0;
    last = 1'b0;
    t = 0;
    while (busy1 && t < 2000) begin tick; t++; end
    check("div1_busy_end", busy1, 0);
    check("div1_cs_low", last_low1, CS_SETUP + 3 * 64 + 2 + 1);
    check("div1_loopback", rxw1, 32'h600D_0002);
    check("sat_ws", ws1, 16'hFFFF);
    repeat (20) tick;
    check("sat_hold", ws1, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
